// File: rtl/response_writer.sv
// response_writer: Avalon-MM write master that drains a 64-bit word stream
// into a circular buffer in SDRAM, one single-beat write per word.
module response_writer #(
  parameter int unsigned BUF_ADDRESS     = 0,
  parameter int unsigned BUF_WORDS       = 1024,
  parameter int unsigned FIFO_DEPTH      = 32,
  parameter int unsigned FIFO_DEPTH_LOG2 = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        restart,
  output logic        idle,
  output logic [31:0] words_written,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [28:0] write_address,
  output logic [7:0]  write_burstcount,
  output logic [7:0]  write_byteenable,
  output logic [63:0] write_writedata,
  output logic        write_write,
  input  logic        write_waitrequest
);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    FLUSH   = 3'd1,
    RESTART = 3'd2,
    CLEAR   = 3'd3,
    RUN     = 3'd4
  } state_t;

  localparam logic [28:0] PC_BASE = 29'(BUF_ADDRESS / 8);
  localparam logic [28:0] PC_LAST = 29'(BUF_ADDRESS / 8 + BUF_WORDS - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);

  state_t state;
  logic [28:0] pc;
  logic        fifo_sclr;

  logic [63:0]                fifo_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   fifo_count;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic [63:0]                fifo_q;
  logic                       push;
  logic                       pop;
  logic                       stall;

  assign write_burstcount = 8'h01;
  assign write_byteenable = 8'hFF;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign fifo_q     = fifo_mem[rd_ptr];

  assign stall    = write_write && write_waitrequest;
  assign in_ready = (state == RUN) && !restart && !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == RUN) && !restart && !stall && !fifo_empty;
  assign idle     = (state == RUN) && fifo_empty && !write_write && !restart;

  // FIFO storage: written on every accepted push
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy, cleared synchronously by fifo_sclr
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (fifo_sclr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Control FSM with registered Avalon outputs, write pointer and counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= INIT;
      pc              <= PC_BASE;
      fifo_sclr       <= 1'b0;
      write_write     <= 1'b0;
      write_address   <= '0;
      write_writedata <= '0;
      words_written   <= '0;
    end else begin
      // Only writes accepted while running are counted; RESTART clears anyway
      if (state == RUN && write_write && !write_waitrequest)
        words_written <= words_written + 32'd1;
      case (state)
        INIT: begin
          if (restart) state <= FLUSH;
        end
        FLUSH: begin
          if (!stall) begin
            write_write <= 1'b0;
            state       <= RESTART;
          end
        end
        RESTART: begin
          pc            <= PC_BASE;
          words_written <= '0;
          fifo_sclr     <= 1'b1;
          if (!restart) state <= CLEAR;
        end
        CLEAR: begin
          fifo_sclr <= 1'b0;
          state     <= restart ? FLUSH : RUN;
        end
        RUN: begin
          if (restart) begin
            // A stalled request stays on the bus; FLUSH waits for it
            state <= FLUSH;
            if (!stall) write_write <= 1'b0;
          end else if (pop) begin
            write_writedata <= fifo_q;
            write_address   <= pc;
            write_write     <= 1'b1;
            pc              <= (pc == PC_LAST) ? PC_BASE : pc + 29'd1;
          end else if (!stall) begin
            write_write <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
          if (!stall) write_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_response_writer.sv
// Testbench for response_writer: vector table for the basic burst, scoreboard
// for every write, hand-written sequences for stall, wrap, restart and reset.
module tb_response_writer;

  localparam int unsigned BUF_ADDRESS     = 32'h0000_0800;
  localparam int unsigned BUF_WORDS       = 4;
  localparam int unsigned FIFO_DEPTH      = 32;
  localparam int unsigned FIFO_DEPTH_LOG2 = 5;
  localparam logic [28:0] BASE = 29'(BUF_ADDRESS / 8);

  logic        clock;
  logic        reset_n;
  logic        restart;
  logic        idle;
  logic [31:0] words_written;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [28:0] write_address;
  logic [7:0]  write_burstcount;
  logic [7:0]  write_byteenable;
  logic [63:0] write_writedata;
  logic        write_write;
  logic        write_waitrequest;

  response_writer #(
    .BUF_ADDRESS    (BUF_ADDRESS),
    .BUF_WORDS      (BUF_WORDS),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .restart          (restart),
    .idle             (idle),
    .words_written    (words_written),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .write_address    (write_address),
    .write_burstcount (write_burstcount),
    .write_byteenable (write_byteenable),
    .write_writedata  (write_writedata),
    .write_write      (write_write),
    .write_waitrequest(write_waitrequest)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [28:0] a;
    logic [63:0] d;
  } sb_t;

  sb_t         sb[$];
  logic [28:0] acc_addr[$];
  int          acc_total  = 0;
  int          push_count = 0;
  logic [28:0] exp_pc     = BASE;

  typedef struct {
    bit          valid;
    logic [63:0] data;
    bit          ready;
    bit          ww;
    logic [28:0] addr;
    logic [63:0] wdata;
    logic [31:0] count;
    bit          idl;
  } vec_t;

  vec_t tv[7];

  function automatic logic [28:0] next_pc(input logic [28:0] p);
    return (p == BASE + 29'(BUF_WORDS - 1)) ? BASE : p + 29'd1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected write recorded at push, compared while the write is on the bus
  always @(negedge clock) begin
    if (reset_n) begin
      if (in_valid && in_ready) begin
        sb_t e;
        e.a = exp_pc;
        e.d = in_data;
        sb.push_back(e);
        exp_pc = next_pc(exp_pc);
      end
      if (write_write) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_unexpected_write: got addr %0h data %0h expected no write",
                   write_address, write_writedata);
        end else begin
          check("sb_addr", write_address, sb[0].a);
          check("sb_data", write_writedata, sb[0].d);
        end
        if (!write_waitrequest) begin
          acc_addr.push_back(write_address);
          acc_total++;
          if (sb.size() != 0) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (!idle && n < 500) begin
      @(negedge clock);
      n++;
    end
    check(name, idle, 1);
  endtask

  task automatic do_restart(input int cycles);
    @(posedge clock);
    #1 restart = 1'b1;
    repeat (cycles) @(posedge clock);
    #1 restart = 1'b0;
    wait_idle("restart_idle");
    sb.delete();
    exp_pc = BASE;
  endtask

  task automatic push_words(input int n, input logic [63:0] base_data);
    int sent;
    int cyc;
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < 2000) begin
      @(posedge clock);
      #1 in_valid = 1'b1;
      in_data = base_data + 64'(sent);
      @(negedge clock);
      if (in_ready) begin
        sent++;
        push_count++;
      end
      cyc++;
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
    check("push_done", sent, n);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ww"}, write_write, 0);
    check({tag, "_addr"}, write_address, 0);
    check({tag, "_data"}, write_writedata, 0);
    check({tag, "_count"}, words_written, 0);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_idle"}, idle, 0);
    check({tag, "_burst"}, write_burstcount, 8'h01);
    check({tag, "_be"}, write_byteenable, 8'hFF);
  endtask

  initial begin
    int bad_ready;
    int bad_ww;
    int snap;
    int n;

    reset_n           = 1'b0;
    restart           = 1'b0;
    in_valid          = 1'b0;
    in_data           = '0;
    write_waitrequest = 1'b0;

    tv[0] = '{1'b1, 64'h11, 1'b1, 1'b0, 29'h0,     64'h0,  32'd0, 1'b1};
    tv[1] = '{1'b1, 64'h22, 1'b1, 1'b0, 29'h0,     64'h0,  32'd0, 1'b0};
    tv[2] = '{1'b1, 64'h33, 1'b1, 1'b1, BASE,      64'h11, 32'd0, 1'b0};
    tv[3] = '{1'b1, 64'h44, 1'b1, 1'b1, BASE + 1,  64'h22, 32'd1, 1'b0};
    tv[4] = '{1'b0, 64'h0,  1'b1, 1'b1, BASE + 2,  64'h33, 32'd2, 1'b0};
    tv[5] = '{1'b0, 64'h0,  1'b1, 1'b1, BASE + 3,  64'h44, 32'd3, 1'b0};
    tv[6] = '{1'b0, 64'h0,  1'b1, 1'b0, 29'h0,     64'h0,  32'd4, 1'b1};

    // Reset values, then INIT ignores input for 100 cycles
    #12;
    check_reset_values("rst");
    #10 reset_n = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b1;
    in_data = 64'hDEAD;
    bad_ready = 0;
    bad_ww    = 0;
    repeat (100) begin
      @(negedge clock);
      if (in_ready)    bad_ready++;
      if (write_write) bad_ww++;
    end
    check("init_in_ready_cycles", bad_ready, 0);
    check("init_write_cycles", bad_ww, 0);
    check("init_count", words_written, 0);
    @(posedge clock);
    #1 in_valid = 1'b0;

    // Basic four-word burst
    do_restart(1);
    for (int i = 0; i < 7; i++) begin
      @(posedge clock);
      #1 in_valid = tv[i].valid;
      in_data = tv[i].data;
      @(negedge clock);
      check($sformatf("t1_ready_%0d", i), in_ready, tv[i].ready);
      check($sformatf("t1_ww_%0d", i), write_write, tv[i].ww);
      if (tv[i].ww) begin
        check($sformatf("t1_addr_%0d", i), write_address, tv[i].addr);
        check($sformatf("t1_data_%0d", i), write_writedata, tv[i].wdata);
      end
      check($sformatf("t1_count_%0d", i), words_written, tv[i].count);
      check($sformatf("t1_idle_%0d", i), idle, tv[i].idl);
    end

    // Stall on first write, fill FIFO, then drain with random waitrequest
    push_count = 0;
    @(posedge clock);
    #1 write_waitrequest = 1'b1;
    fork
      push_words(40, 64'h1000);
      begin
        n = 0;
        do begin
          @(negedge clock);
          n++;
        end while (!write_write && n < 20);
        check("t2_ww_seen", write_write, 1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clock);
          check("t2_hold_ww", write_write, 1);
          check("t2_hold_addr", write_address, BASE);
          check("t2_hold_data", write_writedata, 64'h1000);
        end
        for (n = 0; n < 80 && in_ready; n++) @(negedge clock);
        check("t2_full_ready", in_ready, 0);
        check("t2_full_pushes", push_count, FIFO_DEPTH + 1);
        for (int i = 0; i < 1000; i++) begin
          if (push_count == 40 && sb.size() == 0 && !write_write) break;
          @(posedge clock);
          #1 write_waitrequest = ($urandom_range(3) == 0);
        end
        write_waitrequest = 1'b0;
      end
    join
    wait_idle("t2_idle");
    check("t2_sb_empty", sb.size(), 0);
    check("t2_count", words_written, 44);

    // Wrap at BUF_WORDS
    do_restart(1);
    acc_addr.delete();
    push_words(6, 64'h3000);
    wait_idle("t3_idle");
    check("t3_count", words_written, 6);
    check("t3_writes", acc_addr.size(), 6);
    for (int i = 0; i < 6 && i < acc_addr.size(); i++)
      check($sformatf("t3_addr_%0d", i), acc_addr[i], BASE + 29'(i % 4));

    // Restart while a write is stalled with 10 words queued (pc sits at base+2)
    @(posedge clock);
    #1 write_waitrequest = 1'b1;
    push_words(11, 64'h4000);
    @(negedge clock);
    check("t4_stalled", write_write, 1);
    snap = acc_total;
    @(posedge clock);
    #1 restart = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("t4_rs_ww", write_write, 1);
      check("t4_rs_addr", write_address, BASE + 2);
      check("t4_rs_data", write_writedata, 64'h4000);
    end
    @(posedge clock);
    #1 restart = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("t4_flush_ww", write_write, 1);
    end
    @(posedge clock);
    #1 write_waitrequest = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("t4_ww_dropped", write_write, 0);
    wait_idle("t4_idle");
    check("t4_count", words_written, 0);
    check("t4_accepts", acc_total - snap, 1);
    sb.delete();
    exp_pc = BASE;
    acc_addr.delete();
    push_words(1, 64'h4ABC);
    wait_idle("t4_idle2");
    check("t4_next_writes", acc_addr.size(), 1);
    if (acc_addr.size() > 0) check("t4_next_addr", acc_addr[0], BASE);
    check("t4_next_count", words_written, 1);

    // Asynchronous reset in the middle of a burst
    @(posedge clock);
    #1 in_valid = 1'b1;
    in_data = 64'h6000;
    repeat (3) begin
      @(posedge clock);
      #1 in_data = in_data + 64'd1;
    end
    @(negedge clock);
    check("t6_midburst", write_write, 1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_values("t6_rst");
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    sb.delete();
    exp_pc = BASE;
    do_restart(2);
    acc_addr.delete();
    push_words(2, 64'h7000);
    wait_idle("t6_idle");
    check("t6_writes", acc_addr.size(), 2);
    if (acc_addr.size() > 1) begin
      check("t6_addr0", acc_addr[0], BASE);
      check("t6_addr1", acc_addr[1], BASE + 1);
    end
    check("t6_count", words_written, 2);
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
